// File: rtl/uart_line_parser_pkg.sv
// rtl/uart_line_parser_pkg.sv - shared constants, FSM encoding and byte classification
package uart_line_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam int MAX_DIGITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_CONV   = 3'd2,
        ST_ECHO   = 3'd3,
        ST_TX_GAP = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_backspace(input logic [7:0] b);
        return (b == ASCII_BS) || (b == ASCII_DEL);
    endfunction

    function automatic logic is_enter(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_line_parser_if.sv
// rtl/uart_line_parser_if.sv - uart register-port bundle between parser and uart
interface uart_line_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_re;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_we;

    // master is the parser side, slave is the uart side
    modport master (input rx_data, rx_valid, tx_busy, output rx_re, tx_data, tx_we);
    modport slave  (output rx_data, rx_valid, tx_busy, input rx_re, tx_data, tx_we);
endinterface

// File: rtl/uart_line_parser_bcd4_to_bin.sv
// rtl/uart_line_parser_bcd4_to_bin.sv - iterative 4-digit BCD to binary, one digit per cycle, MSD first
module bcd4_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] bcd_i,
    output logic        done_o,
    output logic [15:0] result_o
);
    logic [15:0] acc_q, acc_d;
    logic [15:0] shreg_q, shreg_d;
    logic [1:0]  step_q, step_d;
    logic        run_q, run_d;
    logic [15:0] acc_next;

    // max 999*10+9 fits in 16 bits, so no widening is needed
    assign acc_next = (acc_q * 16'd10) + {12'd0, shreg_q[15:12]};
    assign done_o   = run_q && (step_q == 2'd3);
    assign result_o = acc_next;

    always_comb begin
        acc_d   = acc_q;
        shreg_d = shreg_q;
        step_d  = step_q;
        run_d   = run_q;
        if (start_i) begin
            acc_d   = 16'd0;
            shreg_d = bcd_i;
            step_d  = 2'd0;
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d   = acc_next;
            shreg_d = {shreg_q[11:0], 4'h0};
            step_d  = step_q + 2'd1;
            run_d   = (step_q != 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= 16'd0;
            shreg_q <= 16'd0;
            step_q  <= 2'd0;
            run_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            step_q  <= step_d;
            run_q   <= run_d;
        end
    end
endmodule

// File: rtl/uart_line_parser.sv
// rtl/uart_line_parser.sv - keystroke line editor: collects up to 4 decimal digits, echoes, converts on Enter
module uart_line_parser
    import uart_line_pkg::*;
#(
    parameter bit ECHO_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_line_parser_if.master         uart,
    output logic [15:0]                bcd_disp,
    output logic [2:0]                 digit_cnt,
    output logic [15:0]                num_out,
    output logic                       num_valid,
    output logic                       ovf_err,
    output logic                       busy
);
    state_e state_q, state_d;

    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      num_q, num_d;
    logic             num_valid_q, num_valid_d;
    logic [3:0][7:0]  echo_q, echo_d;
    logic [1:0]       echo_len_q, echo_len_d;
    logic [1:0]       echo_idx_q, echo_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic        dig, bksp, enter, has_room, has_digits;
    logic        conv_start, conv_done;
    logic [15:0] conv_result;
    logic        rx_re_c, tx_we_c, busy_c;
    state_e      echo_or_idle;

    assign dig          = is_digit(rx_byte_q);
    assign bksp         = is_backspace(rx_byte_q);
    assign enter        = is_enter(rx_byte_q);
    assign has_room     = cnt_q < 3'(MAX_DIGITS);
    assign has_digits   = cnt_q != 3'd0;
    assign echo_or_idle = ECHO_EN ? ST_ECHO : ST_IDLE;

    bcd4_to_bin u_conv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (conv_start),
        .bcd_i    (bcd_q),
        .done_o   (conv_done),
        .result_o (conv_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (uart.rx_valid) state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = ST_IDLE;
                if ((dig && has_room) || (bksp && has_digits)) state_d = echo_or_idle;
                else if (enter) state_d = has_digits ? ST_CONV : echo_or_idle;
            end
            ST_CONV:   if (conv_done) state_d = echo_or_idle;
            ST_ECHO:   if (!uart.tx_busy) state_d = ST_TX_GAP;
            ST_TX_GAP: state_d = (echo_idx_q < echo_len_q) ? ST_ECHO : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_re_c    = (state_q == ST_DECODE);
        tx_we_c    = (state_q == ST_TX_GAP);
        busy_c     = (state_q != ST_IDLE);
        conv_start = (state_q == ST_DECODE) && enter && has_digits;
    end

    always_comb begin
        rx_byte_d   = rx_byte_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        num_d       = num_q;
        num_valid_d = 1'b0;
        echo_d      = echo_q;
        echo_len_d  = echo_len_q;
        echo_idx_d  = echo_idx_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_IDLE: if (uart.rx_valid) rx_byte_d = uart.rx_data;
            ST_DECODE: begin
                if (dig && has_room) begin
                    bcd_d      = {bcd_q[11:0], rx_byte_q[3:0]};
                    cnt_d      = cnt_q + 3'd1;
                    echo_d[0]  = rx_byte_q;
                    echo_len_d = 2'd1;
                    echo_idx_d = 2'd0;
                end else if (dig) begin
                    ovf_d = 1'b1;
                end else if (bksp && has_digits) begin
                    bcd_d      = {4'h0, bcd_q[15:4]};
                    cnt_d      = cnt_q - 3'd1;
                    echo_d[0]  = ASCII_BS;
                    echo_d[1]  = ASCII_SPACE;
                    echo_d[2]  = ASCII_BS;
                    echo_len_d = 2'd3;
                    echo_idx_d = 2'd0;
                end else if (enter) begin
                    echo_d[0]  = ASCII_CR;
                    echo_d[1]  = ASCII_LF;
                    echo_len_d = 2'd2;
                    echo_idx_d = 2'd0;
                end
            end
            ST_CONV: if (conv_done) begin
                num_d       = conv_result;
                bcd_d       = 16'd0;
                cnt_d       = 3'd0;
                ovf_d       = 1'b0;
                num_valid_d = 1'b1;
            end
            ST_ECHO: if (!uart.tx_busy) begin
                tx_data_d  = echo_q[echo_idx_q];
                echo_idx_d = echo_idx_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_q   <= 8'd0;
            bcd_q       <= 16'd0;
            cnt_q       <= 3'd0;
            ovf_q       <= 1'b0;
            num_q       <= 16'd0;
            num_valid_q <= 1'b0;
            echo_q      <= '0;
            echo_len_q  <= 2'd0;
            echo_idx_q  <= 2'd0;
            tx_data_q   <= 8'd0;
        end else begin
            rx_byte_q   <= rx_byte_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            echo_q      <= echo_d;
            echo_len_q  <= echo_len_d;
            echo_idx_q  <= echo_idx_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign uart.rx_re   = rx_re_c;
    assign uart.tx_we   = tx_we_c;
    assign uart.tx_data = tx_data_q;
    assign bcd_disp     = bcd_q;
    assign digit_cnt    = cnt_q;
    assign num_out      = num_q;
    assign num_valid    = num_valid_q;
    assign ovf_err      = ovf_q;
    assign busy         = busy_c;
endmodule

// File: doc/uart_line_parser.md
UART_LINE_PARSER -- requirements
Module: uart_line_parser

Interface
REQ-001 Parameter ECHO_EN, default 1, meaning: 1 = echo accepted keystrokes on TX, 0 = no TX activity.
REQ-002 clk  in  1  system clock (100 MHz domain, same clock as uart).
REQ-003 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 rx_data  in  8  received byte from uart reg_dat_do.
REQ-005 rx_valid  in  1  level; uart holds a received byte until read.
REQ-006 rx_re  out  1  one-cycle read acknowledge to uart reg_dat_re.
REQ-007 tx_busy  in  1  uart transmitter busy.
REQ-008 tx_data  out  8  echo byte to uart reg_dat_di.
REQ-009 tx_we  out  1  one-cycle write strobe to uart reg_dat_we.
REQ-010 bcd_disp  out  16  four BCD digits of the current entry, least significant digit in [3:0], for the 7-segment driver.
REQ-011 digit_cnt  out  3  digits held, 0..4.
REQ-012 num_out  out  16  binary value of the last committed line.
REQ-013 num_valid  out  1  one-cycle pulse when num_out updates.
REQ-014 ovf_err  out  1  sticky flag: a digit was rejected on the current line.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, DECODE, CONV, ECHO and TX_GAP.
REQ-017 IDLE with rx_valid=1 at an edge SHALL latch rx_data and enter DECODE; rx_re SHALL be high during exactly the DECODE cycle.
REQ-018 In IDLE, rx_valid=0 SHALL hold the state.
REQ-019 The block SHALL never sample rx_valid outside IDLE; unread bytes remain in uart as backpressure.
REQ-020 Digit 0x30-0x39 with digit_cnt<4: the edge ending DECODE SHALL shift bcd_disp left 4 bits, insert the digit and increment digit_cnt; the echo queue is {byte}.
REQ-021 Digit with digit_cnt=4: bcd_disp and digit_cnt unchanged; ovf_err SHALL be set to 1; no echo.
REQ-022 Backspace 0x08 or 0x7F with digit_cnt>0: bcd_disp shifts right 4 bits, zero-filled; digit_cnt decrements; echo queue {0x08,0x20,0x08}.
REQ-023 Backspace with digit_cnt=0: no state change and no echo.
REQ-024 Enter 0x0D or 0x0A with digit_cnt>0: go to CONV.
REQ-025 Enter with digit_cnt=0: skip CONV and do not pulse num_valid.
REQ-026 In both Enter cases the echo queue SHALL be {0x0D,0x0A}.
REQ-027 CONV SHALL take exactly 4 cycles, MSD first: acc = acc*10 + digit, 16-bit unsigned; result at most 9999, so no overflow.
REQ-028 The edge ending CONV SHALL load num_out and clear bcd_disp, digit_cnt and ovf_err.
REQ-029 num_valid SHALL be high during the cycle after CONV.
REQ-030 Any other byte SHALL be discarded silently.
REQ-031 Empty echo queue or ECHO_EN=0: the DECODE or CONV exit SHALL go to IDLE; otherwise it SHALL go to ECHO.
REQ-032 ECHO with tx_busy=0 SHALL register tx_data and go to TX_GAP, where tx_we is high for exactly one cycle.
REQ-033 From TX_GAP the FSM SHALL go to ECHO if bytes remain, else to IDLE.
REQ-034 ECHO with tx_busy=1 SHALL wait indefinitely.
REQ-035 Echo bytes SHALL be emitted in queue order, with at most one tx_we per TX_GAP.
REQ-036 Latency: rx_valid sampled at edge N gives rx_re in cycle N+1 and bcd_disp updated from cycle N+2.

Reset
REQ-037 rst=1 at any edge, including mid-CONV or mid-echo, SHALL force IDLE and clear all outputs, the accumulator and the echo queue to 0.
REQ-038 A byte pending in uart during reset SHALL be processed normally after reset is released.

Structure
REQ-039 Package uart_line_pkg SHALL hold the ASCII constants (CR, LF, BS, DEL, SPACE, '0', '9'), the FSM state encoding and MAX_DIGITS=4.
REQ-040 One sub-module, bcd4_to_bin, SHALL implement the 4-cycle iterative conversion with start/done handshake; all other logic stays in uart_line_parser.

Verification
REQ-041 Bytes "1","2","3",0x0D, tx_busy=0 -> echo 31 32 33 0D 0A; num_out=123; one num_valid pulse; bcd_disp=0x0000 afterwards.
REQ-042 Bytes "9","8","7","6","5",0x0D -> echo lacks 35; ovf_err=1 before Enter and 0 after; num_out=9876.
REQ-043 Bytes "4","2",0x7F,"7",0x0A -> echo 34 32 08 20 08 37 0D 0A; num_out=47.
REQ-044 0x0D with an empty entry -> echo 0D 0A; no num_valid; num_out unchanged.
REQ-045 tx_busy held high for 200 cycles while "5" is echoed -> tx_we stays low until busy falls, then exactly one pulse; a second byte waiting in rx is not acknowledged until IDLE.
REQ-046 rst during the second CONV cycle of "99",0x0D -> all outputs 0, no num_valid; a subsequent "3",0x0D yields num_out=3.
